eth_rx_hdr_filter: RTL
======================

# eth_rx_hdr_filter

Receive-side Ethernet header parser and destination-address filter in the `logic_clk` domain. It sits directly downstream of the MII MAC + FIFO receive output. It consumes the 8-bit AXI-stream frame, captures the 14-byte Ethernet header, and applies the destination MAC filter. Accepted frames are presented as a header-field bundle plus a payload stream; rejected or truncated frames are silently discarded with a status pulse.

## Interface
- `ENABLE_BROADCAST`, 1: accept dest ff:ff:ff:ff:ff:ff.
- `ENABLE_MULTICAST`, 0: accept any dest with the I/G bit set (`dest[40]`, LSB of first byte).
- `logic_clk` in 1: single clock; all logic on rising edge.
- `logic_rst` in 1: reset is synchronous and active-high.
- `s_axis_tdata` in 8: frame byte from MAC RX FIFO.
- `s_axis_tvalid` in 1: input valid.
- `s_axis_tready` out 1: input ready.
- `s_axis_tlast` in 1: last byte of frame.
- `s_axis_tuser` in 1: bad-frame flag, meaningful only with tlast.
- `m_eth_hdr_valid` out 1: header fields valid.
- `m_eth_hdr_ready` in 1: header accepted.
- `m_eth_dest_mac` out 48: bytes 0–5, byte 0 in [47:40].
- `m_eth_src_mac` out 48: bytes 6–11, byte 6 in [47:40].
- `m_eth_type` out 16: bytes 12–13, byte 12 in [15:8].
- `m_eth_payload_axis_tdata` out 8: payload byte.
- `m_eth_payload_axis_tvalid` out 1: payload valid.
- `m_eth_payload_axis_tready` in 1: payload ready.
- `m_eth_payload_axis_tlast` out 1: last payload byte.
- `m_eth_payload_axis_tuser` out 1: copy of input tuser on the last byte; 0 otherwise.
- `local_mac` in 48: station address, same byte order as dest.
- `promisc_en` in 1: accept all destinations.
- `busy` out 1: state ≠ IDLE.
- `error_header_early_termination` out 1: one-cycle pulse.
- `frame_filtered` out 1: one-cycle pulse when a complete header fails the filter.

## Operation
**States**
- **IDLE/HDR:** `s_axis_tready`=1. Each accepted byte is shifted into the capture register and the header counter (4 bits, 0..13) increments.
- **DROP:** `s_axis_tready`=1. Bytes are discarded until an accepted tlast returns the block to IDLE; the counter is cleared.
- **PAYLOAD:** `s_axis_tready` = !`m_eth_hdr_valid` && (!`m_eth_payload_axis_tvalid` || `m_eth_payload_axis_tready`). The first payload byte cannot be forwarded until the header handshake completes. An accepted tlast returns the block to IDLE.

**Header completion** (byte 13 accepted without tlast)
- The filter is evaluated on the full 48-bit dest: match = `promisc_en` | (dest==`local_mac`) | (`ENABLE_BROADCAST` & dest==48'hffffffffffff) | (`ENABLE_MULTICAST` & dest[40]).
- **On match:** load the output header registers, set `m_eth_hdr_valid`, go to PAYLOAD.
- **On no match:** pulse `frame_filtered`, go to DROP.

**Early termination**
- tlast accepted on any header byte 0..13 pulses `error_header_early_termination`, emits nothing, and returns to IDLE.
- This includes a 14-byte frame (no payload).

**Output rules**
- `m_eth_hdr_valid` clears on `m_eth_hdr_ready`.
- Header outputs hold stable while valid.
- Payload is forwarded unmodified, including any FCS/pad the MAC left; tuser propagates only on tlast.
- A bad frame (tuser=1) with a matching header is still forwarded; downstream decides.

## Timing
- **Reset:** state IDLE, counter 0, all outputs 0 (`s_axis_tready` becomes 1 the cycle after reset deasserts).
- **Header latency:** `m_eth_hdr_valid` rises the cycle after byte 13 is accepted.
- **Payload latency:** registered output stage, 1 cycle input-to-output; full throughput of 1 byte/cycle with ready held high.
- **Status pulses:** both are asserted the cycle after the triggering byte is accepted, for exactly 1 cycle.
- **Mid-frame reset:**
  - Immediate return to IDLE; pending header and payload valids are dropped.
  - Input bytes following reset are parsed as a new frame header.
- **Back-to-back frames:** byte 0 of the next frame may be accepted the cycle after the previous tlast.

## Test plan
- **Unicast match:** `local_mac`=02:00:00:00:00:01; send a 60-byte frame to it from 02:00:00:00:00:02, type 0x0800, payload 0x00..0x2D.
  - Header: dest/src/type as sent.
  - Payload: 46 bytes, tlast on 0x2D, tuser 0.
- **Filtered and broadcast:** dest 02:00:00:00:00:09 -> one `frame_filtered` pulse, no outputs, all bytes consumed. Dest ff:ff:ff:ff:ff:ff with `ENABLE_BROADCAST`=1 -> forwarded; with `promisc_en`=1 any dest -> forwarded.
- **Early termination:** a 10-byte frame and a 14-byte frame each -> one `error_header_early_termination` pulse, no header valid. The next 64-byte frame is parsed correctly.
- **Backpressure:**
  - Hold `m_eth_hdr_ready`=0 for 20 cycles -> `s_axis_tready`=0, no payload output.
  - Toggle payload ready randomly -> byte order and count are preserved, with no duplicates or losses.
- **Bad frame:** a matching 64-byte frame with tuser=1 on tlast -> forwarded, with `m_eth_payload_axis_tuser`=1 only on the last byte.
- **Reset mid-payload:** assert `logic_rst` for 1 cycle at payload byte 20 -> all valids 0 next cycle and `busy`=0. A fresh frame afterwards is received correctly.

Source files
------------

// File: rtl/eth_rx_hdr_filter.sv
// Receive-side Ethernet header parser with destination MAC filtering.
// Splits an 8-bit AXI-stream frame into a 14-byte header bundle and a payload stream.
module eth_rx_hdr_filter #(
    parameter bit ENABLE_BROADCAST = 1'b1,
    parameter bit ENABLE_MULTICAST = 1'b0
) (
    input  logic        logic_clk,
    input  logic        logic_rst,

    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,

    output logic        m_eth_hdr_valid,
    input  logic        m_eth_hdr_ready,
    output logic [47:0] m_eth_dest_mac,
    output logic [47:0] m_eth_src_mac,
    output logic [15:0] m_eth_type,

    output logic [7:0]  m_eth_payload_axis_tdata,
    output logic        m_eth_payload_axis_tvalid,
    input  logic        m_eth_payload_axis_tready,
    output logic        m_eth_payload_axis_tlast,
    output logic        m_eth_payload_axis_tuser,

    input  logic [47:0] local_mac,
    input  logic        promisc_en,

    output logic        busy,
    output logic        error_header_early_termination,
    output logic        frame_filtered
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DROP,
        PAYLOAD
    } state_t;

    state_t        state;
    logic [3:0]    hdr_cnt;
    logic [103:0]  hdr_shift;
    logic          ready_en;

    logic [111:0]  hdr_full;
    logic [47:0]   dest_full;
    logic          filter_match;
    logic          payload_room;
    logic          in_fire;

    // The header bundle as it would look if the current byte were byte 13.
    assign hdr_full  = {hdr_shift, s_axis_tdata};
    assign dest_full = hdr_full[111:64];

    assign filter_match = promisc_en
                        | (dest_full == local_mac)
                        | (ENABLE_BROADCAST && (dest_full == 48'hffff_ffff_ffff))
                        | (ENABLE_MULTICAST && dest_full[40]);

    // Payload bytes wait until the header has been handed off and the output slot is free.
    assign payload_room  = !m_eth_hdr_valid
                         && (!m_eth_payload_axis_tvalid || m_eth_payload_axis_tready);
    assign s_axis_tready = ready_en && ((state != PAYLOAD) || payload_room);
    assign in_fire       = s_axis_tvalid && s_axis_tready;
    assign busy          = (state != IDLE);

    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            state                          <= IDLE;
            hdr_cnt                        <= 4'd0;
            hdr_shift                      <= '0;
            ready_en                       <= 1'b0;
            m_eth_hdr_valid                <= 1'b0;
            m_eth_dest_mac                 <= '0;
            m_eth_src_mac                  <= '0;
            m_eth_type                     <= '0;
            m_eth_payload_axis_tdata       <= '0;
            m_eth_payload_axis_tvalid      <= 1'b0;
            m_eth_payload_axis_tlast       <= 1'b0;
            m_eth_payload_axis_tuser       <= 1'b0;
            error_header_early_termination <= 1'b0;
            frame_filtered                 <= 1'b0;
        end else begin
            ready_en                       <= 1'b1;
            error_header_early_termination <= 1'b0;
            frame_filtered                 <= 1'b0;

            if (m_eth_hdr_valid && m_eth_hdr_ready) begin
                m_eth_hdr_valid <= 1'b0;
            end
            if (m_eth_payload_axis_tvalid && m_eth_payload_axis_tready) begin
                m_eth_payload_axis_tvalid <= 1'b0;
            end

            if (in_fire) begin
                case (state)
                    IDLE, HDR: begin
                        hdr_shift <= hdr_full[103:0];
                        if (s_axis_tlast) begin
                            error_header_early_termination <= 1'b1;
                            hdr_cnt                        <= 4'd0;
                            state                          <= IDLE;
                        end else if (hdr_cnt == 4'd13) begin
                            hdr_cnt <= 4'd0;
                            if (filter_match) begin
                                m_eth_dest_mac  <= hdr_full[111:64];
                                m_eth_src_mac   <= hdr_full[63:16];
                                m_eth_type      <= hdr_full[15:0];
                                m_eth_hdr_valid <= 1'b1;
                                state           <= PAYLOAD;
                            end else begin
                                frame_filtered <= 1'b1;
                                state          <= DROP;
                            end
                        end else begin
                            hdr_cnt <= hdr_cnt + 4'd1;
                            state   <= HDR;
                        end
                    end
                    DROP: begin
                        if (s_axis_tlast) begin
                            state <= IDLE;
                        end
                    end
                    PAYLOAD: begin
                        m_eth_payload_axis_tdata  <= s_axis_tdata;
                        m_eth_payload_axis_tvalid <= 1'b1;
                        m_eth_payload_axis_tlast  <= s_axis_tlast;
                        m_eth_payload_axis_tuser  <= s_axis_tlast && s_axis_tuser;
                        if (s_axis_tlast) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
